// File: rtl/golden_nonce_reporter.sv
// golden_nonce_reporter
// Collects golden nonces from NUM_CORES hashing cores, filters the all-ones
// "no result" pattern, arbitrates round-robin into a small FIFO and paces them
// out to the JTAG nonce FIFO as single-cycle new_nonce strobes.
// Build option: define NONCE_FLUSH_EN to make new_work flush every pending and
// queued nonce. Without it new_work is ignored and stale nonces are reported.
module golden_nonce_reporter #(
  parameter int NUM_CORES  = 4,
  parameter int DEPTH_LOG2 = 3,
  parameter int MIN_GAP    = 2
) (
  input  logic                    clk,
  input  logic                    jt_reset,
  input  logic [NUM_CORES-1:0]    core_valid,
  input  logic [32*NUM_CORES-1:0] core_nonce,
  input  logic                    sink_full,
  input  logic                    new_work,
  output logic                    new_nonce,
  output logic [31:0]             word,
  output logic [DEPTH_LOG2:0]     queue_level,
  output logic [15:0]             drop_count
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam int DCNT_W = $clog2(NUM_CORES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic                  flush;
`ifdef NONCE_FLUSH_EN
  assign flush = new_work;
`else
  logic                  unused_new_work;
  assign flush           = 1'b0;
  assign unused_new_work = new_work;
`endif

  logic [NUM_CORES-1:0]  pend;
  logic [31:0]           hold [NUM_CORES];
  logic [IDX_W-1:0]      last_grant;
  logic                  grant_valid;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_CORES-1:0]  take;
  logic [NUM_CORES-1:0]  drop;
  logic [DCNT_W-1:0]     drop_sum;
  logic [16:0]           drop_total;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  queue_full;
  logic                  do_pop;

  logic [1:0]            state;
  logic [GAP_W-1:0]      gap_cnt;

  // The level can never exceed DEPTH, so its MSB alone marks a full queue.
  assign queue_full = queue_level[DEPTH_LOG2];

  // Round-robin arbiter: search starts one past the last granted core.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    logic [IDX_W:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_CORES)) cand = cand - (IDX_W+1)'(NUM_CORES);
      if (!grant_valid && pend[cand[IDX_W-1:0]] && !queue_full && !flush) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Per-core capture decision: a core whose slot is being granted this edge
  // may refill it at once; otherwise an occupied slot loses the new nonce.
  always_comb begin
    take     = '0;
    drop     = '0;
    drop_sum = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_valid[i] && !flush && (core_nonce[32*i +: 32] != 32'hFFFF_FFFF)) begin
        if (!pend[i] || (grant_valid && (grant_idx == IDX_W'(i)))) take[i] = 1'b1;
        else                                                       drop[i] = 1'b1;
      end
      drop_sum = drop_sum + DCNT_W'(drop[i]);
    end
    drop_total = {1'b0, drop_count} + 17'(drop_sum);
  end

  // Pending flags, arbiter pointer and the saturating drop counter.
  always_ff @(posedge clk or posedge jt_reset) begin
    if (jt_reset) begin
      pend       <= '0;
      last_grant <= IDX_W'(NUM_CORES - 1);
      drop_count <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every block sees pre-edge values.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (take[i])
          pend[i] <= 1'b1;
        else if (flush || (grant_valid && (grant_idx == IDX_W'(i))))
          pend[i] <= 1'b0;
      end
      if (grant_valid) last_grant <= grant_idx;
      drop_count <= drop_total[16] ? 16'hFFFF : drop_total[15:0];
    end
  end

  // Per-core holding registers for captured nonces.
  always_ff @(posedge clk) begin
    // NOTE: data storage is not reset; pend and the queue pointers decide what is valid.
    for (int i = 0; i < NUM_CORES; i++) begin
      if (take[i]) hold[i] <= core_nonce[32*i +: 32];
    end
  end

  // Queue storage: the granted core's held nonce is written at the tail.
  always_ff @(posedge clk) begin
    if (grant_valid) mem[wr_ptr] <= hold[grant_idx];
  end

  // The head is popped only from IDLE, never while the sink is full or a flush is under way.
  assign do_pop = (state == ST_IDLE) && (queue_level != '0) && !sink_full &&
                  (gap_cnt == '0) && !flush;

  // Queue pointers and occupancy; a simultaneous write and pop leave the level unchanged.
  always_ff @(posedge clk or posedge jt_reset) begin
    if (jt_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_level <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_level <= '0;
    end else begin
      if (grant_valid) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({grant_valid, do_pop})
        2'b10:   queue_level <= queue_level + 1'b1;
        2'b01:   queue_level <= queue_level - 1'b1;
        default: queue_level <= queue_level;
      endcase
    end
  end

  // Output pacing FSM. The IDLE cycle that precedes the next pop is itself a
  // low cycle, so GAP only has to cover the remaining MIN_GAP-1 cycles.
  always_ff @(posedge clk or posedge jt_reset) begin
    if (jt_reset) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      new_nonce <= 1'b0;
      word      <= 32'hFFFF_FFFF;
    end else begin
      case (state)
        ST_IDLE: begin
          if (do_pop) begin
            word      <= mem[rd_ptr];
            new_nonce <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          new_nonce <= 1'b0;
          if (MIN_GAP > 1) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_W'(MIN_GAP - 1);
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt <= GAP_W'(1)) state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          new_nonce <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Bench for golden_nonce_reporter: a scoreboard queue holds the nonces each
// scenario expects, and a negedge monitor pops and compares one per pulse.
module tb_golden_nonce_reporter;

  localparam int NUM_CORES  = 4;
  localparam int DEPTH_LOG2 = 3;
  localparam int MIN_GAP    = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                    clk = 1'b0;
  logic                    jt_reset = 1'b0;
  logic [NUM_CORES-1:0]    core_valid = '0;
  logic [32*NUM_CORES-1:0] core_nonce = '0;
  logic                    sink_full = 1'b0;
  logic                    new_work = 1'b0;
  logic                    new_nonce;
  logic [31:0]             word;
  logic [DEPTH_LOG2:0]     queue_level;
  logic [15:0]             drop_count;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] exp_q [$];
  int          obs_t [$];

  golden_nonce_reporter #(
    .NUM_CORES (NUM_CORES),
    .DEPTH_LOG2(DEPTH_LOG2),
    .MIN_GAP   (MIN_GAP)
  ) dut (
    .clk        (clk),
    .jt_reset   (jt_reset),
    .core_valid (core_valid),
    .core_nonce (core_nonce),
    .sink_full  (sink_full),
    .new_work   (new_work),
    .new_nonce  (new_nonce),
    .word       (word),
    .queue_level(queue_level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: every observed pulse must match the oldest expected nonce.
  always @(negedge clk) begin
    if (new_nonce === 1'b1) begin
      obs_t.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: word=%h, expected no pulse", word);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (word !== e) begin
          bad++;
          $display("FAIL pulse_word: got %h want %h", word, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    jt_reset   = 1'b1;
    core_valid = '0;
    new_work   = 1'b0;
    sink_full  = 1'b0;
    tick();
    tick();
    jt_reset = 1'b0;
    tick();
    exp_q.delete();
    obs_t.delete();
  endtask

  task automatic set_core(input int core, input logic [31:0] val);
    core_valid[core]          = 1'b1;
    core_nonce[32*core +: 32] = val;
  endtask

  task automatic test_reset();
    jt_reset = 1'b1;
    #1;
    total++; if (new_nonce !== 1'b0)         begin bad++; $display("FAIL rst_init_new_nonce: got %b want 0", new_nonce); end
    total++; if (word !== 32'hFFFF_FFFF)     begin bad++; $display("FAIL rst_init_word: got %h want ffffffff", word); end
    total++; if (queue_level !== '0)         begin bad++; $display("FAIL rst_init_level: got %0d want 0", queue_level); end
    total++; if (drop_count !== 16'd0)       begin bad++; $display("FAIL rst_init_drops: got %0d want 0", drop_count); end
    apply_reset();
    // Build up queue, pending and drop state, then reset while a pulse is high.
    sink_full = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_core(2, 32'h5000_0000 + i);
      tick();
    end
    core_valid = '0;
    tick();
    total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL rst_pre_drops: got %0d want 3", drop_count); end
    sink_full = 1'b0;
    for (int c = 0; c < 10 && new_nonce !== 1'b1; c++) tick();
    total++; if (new_nonce !== 1'b1) begin bad++; $display("FAIL rst_pre_pulse: got %b want 1", new_nonce); end
    #2;
    jt_reset = 1'b1;
    #1;
    total++; if (new_nonce !== 1'b0)     begin bad++; $display("FAIL rst_mid_new_nonce: got %b want 0", new_nonce); end
    total++; if (word !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_mid_word: got %h want ffffffff", word); end
    total++; if (queue_level !== '0)     begin bad++; $display("FAIL rst_mid_level: got %0d want 0", queue_level); end
    total++; if (drop_count !== 16'd0)   begin bad++; $display("FAIL rst_mid_drops: got %0d want 0", drop_count); end
    set_core(0, 32'h7777_0000);
    tick();
    tick();
    core_valid = '0;
    total++; if (queue_level !== '0) begin bad++; $display("FAIL rst_held_level: got %0d want 0", queue_level); end
    jt_reset = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    total++; if (obs_t.size() != 0) begin bad++; $display("FAIL rst_after_release: got %0d pulses want 0", obs_t.size()); end
  endtask

  task automatic test_single();
    apply_reset();
    exp_q.push_back(32'h1234_ABCD);
    set_core(0, 32'h1234_ABCD);
    tick();
    core_valid = '0;
    total++; if (new_nonce !== 1'b0) begin bad++; $display("FAIL single_e0: got %b want 0", new_nonce); end
    tick();
    total++; if (new_nonce !== 1'b0)   begin bad++; $display("FAIL single_e1: got %b want 0", new_nonce); end
    total++; if (queue_level !== 4'd1) begin bad++; $display("FAIL single_e1_level: got %0d want 1", queue_level); end
    tick();
    total++; if (new_nonce !== 1'b1)     begin bad++; $display("FAIL single_e2: got %b want 1", new_nonce); end
    total++; if (word !== 32'h1234_ABCD) begin bad++; $display("FAIL single_e2_word: got %h want 1234abcd", word); end
    tick();
    total++; if (new_nonce !== 1'b0)     begin bad++; $display("FAIL single_e3: got %b want 0", new_nonce); end
    total++; if (word !== 32'h1234_ABCD) begin bad++; $display("FAIL single_hold_word: got %h want 1234abcd", word); end
    total++; if (exp_q.size() != 0)      begin bad++; $display("FAIL single_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_filter_pacing();
    apply_reset();
    set_core(1, 32'hFFFF_FFFF);
    tick();
    core_valid = '0;
    for (int c = 0; c < 6; c++) tick();
    total++; if (obs_t.size() != 0)    begin bad++; $display("FAIL filter_pulse: got %0d pulses want 0", obs_t.size()); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL filter_drops: got %0d want 0", drop_count); end
    total++; if (queue_level !== '0)   begin bad++; $display("FAIL filter_level: got %0d want 0", queue_level); end
    for (int i = 0; i < NUM_CORES; i++) begin
      exp_q.push_back(32'hA000_0000 + i);
      set_core(i, 32'hA000_0000 + i);
    end
    tick();
    core_valid = '0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL pace_missing: got %0d left want 0", exp_q.size()); end
    total++;
    if (obs_t.size() != NUM_CORES) begin
      bad++; $display("FAIL pace_count: got %0d pulses want %0d", obs_t.size(), NUM_CORES);
    end else begin
      for (int k = 1; k < NUM_CORES; k++) begin
        total++;
        if (obs_t[k] - obs_t[k-1] != MIN_GAP + 1) begin
          bad++; $display("FAIL pace_gap%0d: got %0d low cycles want %0d", k, obs_t[k] - obs_t[k-1] - 1, MIN_GAP);
        end
      end
    end
    for (int c = 0; c < 4; c++) tick();
    total++; if (word !== 32'hA000_0003) begin bad++; $display("FAIL pace_hold_word: got %h want a0000003", word); end
  endtask

  task automatic test_backpressure();
    int exp_drop;
    exp_drop = 0;
    apply_reset();
    sink_full = 1'b1;
    // DEPTH entries fill the queue and one more waits in pend; the rest are lost.
    for (int i = 0; i < 12; i++) begin
      if (i < DEPTH + 1) exp_q.push_back(32'hB000_0000 + i);
      else               exp_drop++;
      set_core(2, 32'hB000_0000 + i);
      tick();
    end
    core_valid = '0;
    tick();
    tick();
    total++; if (queue_level !== 4'(DEPTH))       begin bad++; $display("FAIL bp_level: got %0d want %0d", queue_level, DEPTH); end
    total++; if (drop_count !== 16'(exp_drop))    begin bad++; $display("FAIL bp_drops: got %0d want %0d", drop_count, exp_drop); end
    total++; if (obs_t.size() != 0)               begin bad++; $display("FAIL bp_pulse_while_full: got %0d want 0", obs_t.size()); end
    sink_full = 1'b0;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) tick();
    for (int c = 0; c < 10; c++) tick();
    total++; if (exp_q.size() != 0)         begin bad++; $display("FAIL bp_missing: got %0d left want 0", exp_q.size()); end
    total++; if (obs_t.size() != DEPTH + 1) begin bad++; $display("FAIL bp_count: got %0d pulses want %0d", obs_t.size(), DEPTH + 1); end
    total++; if (queue_level !== '0)        begin bad++; $display("FAIL bp_drained: got %0d want 0", queue_level); end
  endtask

  task automatic test_drop_saturation();
    localparam int K = 16377;
    apply_reset();
    sink_full = 1'b1;
    // All four cores strobing every edge: first edge captures, the next DEPTH
    // edges drop 3 each while the queue fills, then 4 per edge: 3*8 + 4*K = 65532.
    for (int c = 0; c < 1 + DEPTH + K; c++) begin
      for (int i = 0; i < NUM_CORES; i++) set_core(i, 32'hC000_0000 + i);
      tick();
    end
    core_valid = '0;
    set_core(0, 32'hC100_0000);
    tick();
    tick();
    core_valid = '0;
    tick();
    total++; if (queue_level !== 4'(DEPTH)) begin bad++; $display("FAIL sat_level: got %0d want %0d", queue_level, DEPTH); end
    total++; if (drop_count !== 16'hFFFE)   begin bad++; $display("FAIL sat_preload: got %h want fffe", drop_count); end
    for (int i = 0; i < 3; i++) set_core(i, 32'hC200_0000 + i);
    tick();
    core_valid = '0;
    total++; if (drop_count !== 16'hFFFF) begin bad++; $display("FAIL sat_three: got %h want ffff", drop_count); end
    for (int i = 0; i < NUM_CORES; i++) set_core(i, 32'hC300_0000 + i);
    tick();
    core_valid = '0;
    total++; if (drop_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", drop_count); end
    total++; if (obs_t.size() != 0)       begin bad++; $display("FAIL sat_pulse: got %0d want 0", obs_t.size()); end
  endtask

  task automatic test_flush();
    apply_reset();
    sink_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
`ifdef NONCE_FLUSH_EN
      if (i == 0) exp_q.push_back(32'hD000_0000 + i);
`else
      exp_q.push_back(32'hD000_0000 + i);
`endif
      set_core(0, 32'hD000_0000 + i);
      tick();
    end
    core_valid = '0;
    tick();
    tick();
    total++; if (queue_level !== 4'd5) begin bad++; $display("FAIL flush_pre_level: got %0d want 5", queue_level); end
    sink_full = 1'b0;
    for (int c = 0; c < 10 && new_nonce !== 1'b1; c++) tick();
    total++; if (new_nonce !== 1'b1) begin bad++; $display("FAIL flush_first_pulse: got %b want 1", new_nonce); end
    tick();
    new_work = 1'b1;
    tick();
    new_work = 1'b0;
`ifdef NONCE_FLUSH_EN
    total++; if (queue_level !== '0) begin bad++; $display("FAIL flush_level: got %0d want 0", queue_level); end
`endif
    for (int c = 0; c < 30; c++) tick();
    total++; if (exp_q.size() != 0)  begin bad++; $display("FAIL flush_missing: got %0d left want 0", exp_q.size()); end
    total++; if (queue_level !== '0) begin bad++; $display("FAIL flush_end_level: got %0d want 0", queue_level); end
`ifdef NONCE_FLUSH_EN
    total++; if (obs_t.size() != 1) begin bad++; $display("FAIL flush_count: got %0d pulses want 1", obs_t.size()); end
`else
    total++; if (obs_t.size() != 5) begin bad++; $display("FAIL flush_count: got %0d pulses want 5", obs_t.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter_pacing();
    test_backpressure();
    test_drop_saturation();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
